// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampling serial-in parallel-out UART receiver.
// Mid-bit sampling, LSB-first shift, stop-bit check, 1-cycle strobes.
module uart_rx_sipo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ena,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // rxd is asynchronous; only the second flop is ever looked at.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (rxd_s) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end
        end
        // a held-low line must go high before a new start counts
        BRK: begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb_uart_rx_sipo: table, hand-written and random frames for uart_rx_sipo.
// Strobes are scored against an event queue built from frame contents.
module tb_uart_rx_sipo;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int LAT = 2 + CPB/2 + (DB+1)*CPB + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena;
  logic       rxd;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx_sipo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ena(ena),
    .rxd(rxd),
    .dout(dout),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] dout;
    int         at;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         stop_len;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         run = 0;
  int         max_run = 0;
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (reset_n && (valid || frame_err)) begin
      check("strobe_exclusive", 32'(valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, valid, frame_err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(frame_err), 32'(e.err));
        check("strobe_dout", 32'(dout), 32'(e.dout));
        check("strobe_latency", cyc, e.at);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!busy) begin
      run++;
    end else begin
      if (run > max_run) max_run = run;
      run = 0;
    end
  end

  // Called at a negedge; rxd falls at once.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int stop_len, input logic exp_err,
                            input logic [7:0] exp_dout);
    ev_t e;
    e.err  = exp_err;
    e.dout = exp_dout;
    e.at   = cyc + LAT;
    exp_q.push_back(e);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vec[5];
    int         fall;
    logic [7:0] d;
    logic       good;
    int         slen;
    int         gap;

    vec[0] = '{8'hA5, 1'b1, 16, 10, 1'b0, 8'hA5};
    vec[1] = '{8'h00, 1'b1,  9,  0, 1'b0, 8'h00};
    vec[2] = '{8'hFF, 1'b1, 16, 10, 1'b0, 8'hFF};
    vec[3] = '{8'h3C, 1'b0, 56, 20, 1'b1, 8'hFF};
    vec[4] = '{8'h81, 1'b1, 16, 10, 1'b0, 8'h81};

    reset_n = 1'b0;
    ena     = 1'b1;
    rxd     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        run = 0;
        max_run = 0;
      end
      send_frame(vec[i].data, vec[i].stop, vec[i].stop_len,
                 vec[i].exp_err, vec[i].exp_dout);
      if (!vec[i].exp_err) last_good = vec[i].exp_dout;
      idle(vec[i].gap);
      if (i == 2) check("b2b_busy_gap_le1", 32'(max_run <= 1), 1);
      if (i == 3) check("ferr_dout_hold", 32'(dout), 32'hFF);
    end

    // Short low glitch must be rejected as a false start.
    fall = cyc;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("false_start_busy_fall", 32'((cyc - fall) <= 11 && !busy), 1);
    idle(10);

    // Reset mid-frame, partway into bit 4 of 0x5A.
    send_bits(8'h5A, 4);
    d = 8'h5A;
    rxd = d[4];
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_dout", 32'(dout), 0);
    check("midreset_valid", 32'(valid), 0);
    check("midreset_busy", 32'(busy), 0);
    rxd = 1'b1;
    exp_q.delete();
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    send_frame(8'h96, 1'b1, 16, 1'b0, 8'h96);
    last_good = 8'h96;
    idle(10);

    // Drop enable mid-frame on 0x77.
    send_bits(8'h77, 4);
    ena = 1'b0;
    @(negedge clk);
    check("ena_low_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("ena_dout_hold", 32'(dout), 32'h96);
    ena = 1'b1;
    idle(5);
    send_frame(8'h11, 1'b1, 16, 1'b0, 8'h11);
    last_good = 8'h11;
    idle(10);

    // Random frames scored by frame-level rules.
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      if (good) begin
        slen = $urandom_range(9, 20);
        gap  = $urandom_range(0, 15);
        send_frame(d, 1'b1, slen, 1'b0, d);
        last_good = d;
      end else begin
        slen = $urandom_range(12, 40);
        gap  = $urandom_range(2, 20);
        send_frame(d, 1'b0, slen, 1'b1, last_good);
      end
      idle(gap);
    end

    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    idle(20);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
